// File: rtl/car_sensor_counter_pkg.sv
// Shared traffic package.
// Holds the debounce FSM state encodings, the vehicle-count width and
// limit, the default car_wait threshold used by the traffic controller,
// and a saturating increment helper for the count.
package car_sensor_counter_pkg;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;
  localparam int THRESHOLD_DEFAULT = 5;

  // Debounce FSM encodings, kept as plain vectors so that legacy
  // consumers of this package can compare against them directly.
  typedef logic [1:0] deb_state_t;
  localparam deb_state_t ST_IDLE     = 2'd0;
  localparam deb_state_t ST_RISE_CHK = 2'd1;
  localparam deb_state_t ST_PRESENT  = 2'd2;
  localparam deb_state_t ST_FALL_CHK = 2'd3;

  // Increment that holds at CNT_MAX instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/car_sensor_counter_sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer plus debounce FSM for the raw
// city-road loop detector.
// Ports:
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset
//   sensor  - raw, asynchronous, bouncy detector input (1 = vehicle)
//   arrival - one-cycle pulse, high in the cycle the FSM accepts a new
//             vehicle (decoded from registered state only)
module sensor_debounce
  import car_sensor_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor,
  output logic arrival
);

  localparam logic [3:0] DEB_TGT = 4'(DEBOUNCE_CYCLES);

  logic       sync1_q;
  logic       s_sync_q;
  deb_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      s_sync_q <= 1'b0;
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
    end else begin
      sync1_q  <= sensor;
      s_sync_q <= sync1_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
    end
  end

  // The counter holds how many consecutive equal samples have been seen
  // in the current check state; entering a check state already counts
  // the sample that caused the entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    arrival = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_sync_q) begin
          state_d = ST_RISE_CHK;
          cnt_d   = 4'd1;
        end
      end
      ST_RISE_CHK: begin
        if (!s_sync_q) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == DEB_TGT) begin
          // Qualified: the count is updated on this same edge.
          state_d = ST_PRESENT;
          cnt_d   = 4'd0;
          arrival = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_PRESENT: begin
        if (!s_sync_q) begin
          state_d = ST_FALL_CHK;
          cnt_d   = 4'd1;
        end
      end
      ST_FALL_CHK: begin
        if (s_sync_q) begin
          state_d = ST_PRESENT;
          cnt_d   = 4'd0;
        end else if (cnt_q + 4'd1 == DEB_TGT) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

endmodule

// File: rtl/car_sensor_counter.sv
// car_sensor_counter: counts vehicles queued on the city road for the
// traffic controller.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset
//   sensor   - raw loop detector (1 = vehicle present)
//   clear    - synchronous request to empty the queue count
//   carCount - registered waiting-vehicle count, saturating at 7
//   car_wait - registered flag, 1 when carCount >= THRESHOLD
//   overflow - sticky flag, set when an arrival is dropped at saturation;
//              only reset clears it
module car_sensor_counter
  import car_sensor_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int THRESHOLD       = THRESHOLD_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sensor,
  input  logic             clear,
  output logic [CNT_W-1:0] carCount,
  output logic             car_wait,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] THR = CNT_W'(THRESHOLD);

  logic             arrival;
  logic [CNT_W-1:0] count_q, count_d, count_base;
  logic             wait_q, wait_d;
  logic             ovf_q, ovf_d;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clock  (clock),
    .reset  (reset),
    .sensor (sensor),
    .arrival(arrival)
  );

  // Clear is applied before the arrival, so a vehicle qualifying in the
  // same cycle as a clear is still counted.
  always_comb begin
    count_base = clear ? '0 : count_q;
    count_d    = count_base;
    ovf_d      = ovf_q;
    if (arrival) begin
      if (count_base == CNT_MAX) ovf_d = 1'b1;
      count_d = sat_inc(count_base);
    end
    wait_d = (count_d >= THR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wait_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
    end
  end

  assign carCount = count_q;
  assign car_wait = wait_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_car_sensor_counter.sv
module tb_car_sensor_counter;
  import car_sensor_counter_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sensor = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] carCount;
  logic       car_wait;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  car_sensor_counter #(
    .DEBOUNCE_CYCLES(4),
    .THRESHOLD(5)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .sensor  (sensor),
    .clear   (clear),
    .carCount(carCount),
    .car_wait(car_wait),
    .overflow(overflow)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    sensor = 1'b0;
    clear  = 1'b0;
    reset  = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic vehicle();
    sensor = 1'b1;
    tick(8);
    sensor = 1'b0;
    tick(8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #2;
    checks++;
    if (carCount !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d expected 0", carCount);
    end
    checks++;
    if (car_wait !== 1'b0) begin
      errors++;
      $display("FAIL reset_wait: got %b expected 0", car_wait);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf: got %b expected 0", overflow);
    end
    checks++;
    if (dut.u_deb.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dut.u_deb.state_q, ST_IDLE);
    end
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    do_reset();
    sensor = 1'b1;
    tick(5);
    checks++;
    if (carCount !== 3'd0) begin
      errors++;
      $display("FAIL single_edge5: got %0d expected 0", carCount);
    end
    tick(1);
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL single_edge6: got %0d expected 1", carCount);
    end
    tick(4);
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL single_held: got %0d expected 1", carCount);
    end
    checks++;
    if (car_wait !== 1'b0) begin
      errors++;
      $display("FAIL single_wait: got %b expected 0", car_wait);
    end
    sensor = 1'b0;
    tick(8);
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL single_after_depart: got %0d expected 1", carCount);
    end
  endtask

  task automatic test_bounce();
    do_reset();
    sensor = 1'b1; tick(1);
    sensor = 1'b0; tick(1);
    sensor = 1'b1; tick(1);
    sensor = 1'b0; tick(8);
    checks++;
    if (carCount !== 3'd0) begin
      errors++;
      $display("FAIL bounce_count: got %0d expected 0", carCount);
    end
    checks++;
    if (dut.u_deb.state_q !== ST_IDLE) begin
      errors++;
      $display("FAIL bounce_state: got %0d expected %0d", dut.u_deb.state_q, ST_IDLE);
    end
  endtask

  task automatic test_five();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      vehicle();
      checks++;
      if (carCount !== 3'(i)) begin
        errors++;
        $display("FAIL five_count_%0d: got %0d expected %0d", i, carCount, i);
      end
      checks++;
      if (car_wait !== 1'b0) begin
        errors++;
        $display("FAIL five_wait_%0d: got %b expected 0", i, car_wait);
      end
    end
    sensor = 1'b1;
    tick(5);
    checks++;
    if (carCount !== 3'd4 || car_wait !== 1'b0) begin
      errors++;
      $display("FAIL five_pre_edge: got count=%0d wait=%b expected count=4 wait=0", carCount, car_wait);
    end
    tick(1);
    checks++;
    if (carCount !== 3'd5 || car_wait !== 1'b1) begin
      errors++;
      $display("FAIL five_edge: got count=%0d wait=%b expected count=5 wait=1", carCount, car_wait);
    end
    tick(2);
    sensor = 1'b0;
    tick(8);
  endtask

  task automatic test_saturate();
    logic [2:0] exp_cnt;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      vehicle();
      exp_cnt = (i > 7) ? 3'd7 : 3'(i);
      checks++;
      if (carCount !== exp_cnt) begin
        errors++;
        $display("FAIL sat_count_%0d: got %0d expected %0d", i, carCount, exp_cnt);
      end
      checks++;
      if (overflow !== (i >= 8)) begin
        errors++;
        $display("FAIL sat_ovf_%0d: got %b expected %b", i, overflow, (i >= 8));
      end
      checks++;
      if (car_wait !== (i >= 5)) begin
        errors++;
        $display("FAIL sat_wait_%0d: got %b expected %b", i, car_wait, (i >= 5));
      end
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++;
    if (carCount !== 3'd0 || car_wait !== 1'b0) begin
      errors++;
      $display("FAIL sat_clear: got count=%0d wait=%b expected count=0 wait=0", carCount, car_wait);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_ovf_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_clear_arrival();
    do_reset();
    repeat (4) vehicle();
    checks++;
    if (carCount !== 3'd4) begin
      errors++;
      $display("FAIL clr_arr_setup: got %0d expected 4", carCount);
    end
    sensor = 1'b1;
    tick(5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL clr_arr_count: got %0d expected 1", carCount);
    end
    tick(2);
    sensor = 1'b0;
    tick(8);
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL clr_arr_hold: got %0d expected 1", carCount);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vehicle();
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_setup: got %0d expected 1", carCount);
    end
    sensor = 1'b1;
    tick(4);
    reset = 1'b0;
    #2;
    checks++;
    if (carCount !== 3'd0 || car_wait !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: got count=%0d wait=%b ovf=%b expected 0/0/0", carCount, car_wait, overflow);
    end
    tick(1);
    reset = 1'b1;
    tick(5);
    checks++;
    if (carCount !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_edge5: got %0d expected 0", carCount);
    end
    tick(1);
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_edge6: got %0d expected 1", carCount);
    end
    tick(6);
    checks++;
    if (carCount !== 3'd1) begin
      errors++;
      $display("FAIL rstmid_once: got %0d expected 1", carCount);
    end
    sensor = 1'b0;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_single();
    test_bounce();
    test_five();
    test_saturate();
    test_clear_arrival();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/car_sensor_counter.md
CAR_SENSOR_COUNTER -- requirements
Module: car_sensor_counter

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning the number of consecutive equal synchronized samples needed to accept a sensor level change (legal range 2..15).
REQ-002 SHALL have parameter THRESHOLD, default 5, meaning the carCount value at or above which car_wait asserts (legal range 1..7).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sensor, input, 1 bit: raw city-road loop detector; asynchronous and bouncy; 1 means a vehicle is present.
REQ-006 SHALL have port clear, input, 1 bit: synchronous request from the traffic controller to empty the queue count when the city road has been served.
REQ-007 SHALL have port carCount, output, 3 bits: registered waiting-vehicle count, which feeds the controller's carCount input directly.
REQ-008 SHALL have port car_wait, output, 1 bit: registered flag, 1 when carCount >= THRESHOLD.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag, set when an arrival is dropped at saturation.

Function
REQ-010 SHALL synchronize sensor through a 2-flop synchronizer before any other use; the second flop output is s_sync.
REQ-011 SHALL implement a debounce state machine with states IDLE, RISE_CHK, PRESENT and FALL_CHK, plus a 4-bit stability counter.
REQ-012 In IDLE, s_sync=1 SHALL move to RISE_CHK with counter=1; s_sync=0 SHALL stay in IDLE.
REQ-013 In RISE_CHK, s_sync=0 SHALL return to IDLE; s_sync=1 SHALL increment the counter, and on reaching DEBOUNCE_CYCLES SHALL enter PRESENT and generate one arrival event in that same cycle.
REQ-014 In PRESENT, s_sync=0 SHALL move to FALL_CHK with counter=1; otherwise it SHALL stay.
REQ-015 In FALL_CHK, s_sync=1 SHALL return to PRESENT; DEBOUNCE_CYCLES consecutive zeros SHALL enter IDLE; departure SHALL NOT change carCount.
REQ-016 An arrival SHALL update carCount on the (DEBOUNCE_CYCLES+2)th rising edge that samples sensor high, counting the first synchronizer capture as edge 1.
REQ-017 A vehicle held present for any length of time SHALL count exactly once.
REQ-018 On arrival, carCount SHALL increment by 1 and SHALL saturate at 7 (no wrap); an arrival while carCount=7 SHALL set overflow.
REQ-019 clear=1 SHALL set carCount to 0 on the next edge.
REQ-020 clear and arrival in the same cycle SHALL give carCount=1 (clear first, then count the new vehicle).
REQ-021 overflow SHALL be cleared only by reset; clear SHALL NOT clear it.
REQ-022 car_wait SHALL be registered and SHALL update on the same edge as carCount, using the next-state value.
REQ-023 Outputs SHALL be glitch-free registers; no combinational path SHALL exist from sensor or clear to any output.

Reset
REQ-024 reset=0 SHALL immediately force carCount=0, car_wait=0, overflow=0, FSM=IDLE, counter=0 and both synchronizer flops to 0.
REQ-025 Reset asserted mid-debounce SHALL discard the pending event; after release, a still-high sensor SHALL be re-qualified from scratch and counted once.
REQ-026 Reset release SHALL be synchronous to clock at the integration level; the block itself SHALL NOT add a reset synchronizer.

Structure
REQ-027 The shared traffic package SHALL hold the debounce state typedef/encodings, CNT_W=3, CNT_MAX=7 and the default THRESHOLD=5 used by the controller.
REQ-028 The synchronizer plus debounce FSM SHALL be a sub-module named sensor_debounce with an arrival-pulse output; the counter, flags and clear logic SHALL stay in the top.

Verification
REQ-029 Reset released; sensor clean high for 10 cycles -> carCount 0->1 on edge 6 (D=4); single count; car_wait=0.
REQ-030 Sensor bounces 1,0,1,0 on alternate cycles, then low -> carCount stays 0; FSM returns to IDLE.
REQ-031 Five clean vehicles (high 8 cycles, low 8 cycles each) -> carCount=5, car_wait=1 on the edge of the fifth increment.
REQ-032 Nine clean vehicles -> carCount saturates at 7; overflow=1 after the eighth vehicle; a subsequent clear -> carCount=0, car_wait=0, overflow stays 1.
REQ-033 clear pulsed on the exact arrival cycle with carCount=4 -> carCount=1 on the next edge.
REQ-034 reset driven low during RISE_CHK with sensor held high -> outputs 0 asynchronously; after release, carCount=1 on edge 6 after release.
